contador_sched: RTL and testbench



---
 rtl/contador_sched.sv | 125 ++++++++++++
 tb/tb_contador_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_sched.sv
`default_nettype none
// ============================================================================
// Module   : contador_sched
// Purpose  : Round-robin scheduler sharing one WIDTH-bit up-counter between
//            two requesters, with grant/completion pulses and early abort.
// Revision : 1.0 - initial release
// ============================================================================
module contador_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] stop0,
    output logic             ack0,
    output logic             done0,
    input  logic             req1,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] stop1,
    output logic             ack1,
    output logic             done1,
    input  logic             abort,
    output logic [WIDTH-1:0] contador,
    output logic             busy,
    output logic             owner,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_stop;
    logic             r_last;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_win;
    logic             w_load;
    logic             w_finish;
    logic             w_abort_hit;

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = contador;
        w_cnt_inc   = contador + WIDTH'(1);
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_abort_hit = 1'b0;
        // On a tie the requester that did not own the counter last wins.
        w_win       = (req0 & req1) ? ~r_last : req1;

        case (r_state)
            S_IDLE: begin
                if (req0 | req1) begin
                    w_next     = S_GRANT;
                    w_load     = 1'b1;
                    w_cnt_next = w_win ? start1 : start0;
                end
            end
            S_GRANT, S_RUN: begin
                if (abort) begin
                    w_next      = S_DONE;
                    w_finish    = 1'b1;
                    w_abort_hit = 1'b1;
                end else if ((r_state == S_GRANT) && (contador == r_stop)) begin
                    w_next   = S_DONE;
                    w_finish = 1'b1;
                end else begin
                    // The grant cycle already counts as the first step of a run.
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == r_stop) begin
                        w_next   = S_DONE;
                        w_finish = 1'b1;
                    end else begin
                        w_next = S_RUN;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            contador <= '0;
            r_stop   <= '0;
            r_last   <= 1'b1;
            owner    <= 1'b0;
            busy     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            r_state  <= w_next;
            contador <= w_cnt_next;
            busy     <= (w_next != S_IDLE);
            ack0     <= w_load & ~w_win;
            ack1     <= w_load &  w_win;
            done0    <= w_finish & ~owner;
            done1    <= w_finish &  owner;
            aborted  <= w_abort_hit;
            if (w_load) begin
                owner  <= w_win;
                r_last <= w_win;
                r_stop <= w_win ? stop1 : stop0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_contador_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_sched
// Purpose  : Scoreboard bench for contador_sched with a run-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, abort;
    logic [W-1:0] start0, stop0, start1, stop1;
    logic         ack0, ack1, done0, done1, busy, owner, aborted;
    logic [W-1:0] contador;

    contador_sched #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .start0(start0), .stop0(stop0), .ack0(ack0), .done0(done0),
        .req1(req1), .start1(start1), .stop1(stop1), .ack1(ack1), .done1(done1),
        .abort(abort), .contador(contador), .busy(busy), .owner(owner),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        bit           is_done;
        bit           idx;
        logic [W-1:0] cnt;
        bit           ab;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  last_owner;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack/done pulse must match the oldest predicted event.
    always @(negedge clk) begin
        if (!reset && (ack0 || ack1 || done0 || done1)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: ack0=%b ack1=%b done0=%b done1=%b contador=%0d at cycle %0d, none expected",
                         ack0, ack1, done0, done1, contador, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("event_cycle",    cyc,             mon_e.cyc);
                check("event_kind",     done0 | done1,   mon_e.is_done);
                check("event_idx",      ack1 | done1,    mon_e.idx);
                check("event_contador", contador,        mon_e.cnt);
                check("event_aborted",  aborted,         mon_e.ab);
                check("event_owner",    owner,           mon_e.idx);
                check("event_busy",     busy,            1);
            end
        end
    end

    // Requesters drop req on ack and scramble their operands for the next run.
    always @(negedge clk) begin
        if (ack0) begin
            req0 = 1'b0; start0 = W'($urandom); stop0 = W'($urandom);
        end
        if (ack1) begin
            req1 = 1'b0; start1 = W'($urandom); stop1 = W'($urandom);
        end
    end

    // Reference: a run lasts (stop-start) mod 2^W cycles after the grant, at least one.
    function automatic int run_len(input logic [W-1:0] s, input logic [W-1:0] p);
        logic [W-1:0] d;
        d = p - s;
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic push_run(input bit idx, input logic [W-1:0] s, input logic [W-1:0] p,
                            input int t_ack, output int t_done);
        t_done = t_ack + run_len(s, p);
        sb.push_back('{t_ack,  1'b0, idx, s, 1'b0});
        sb.push_back('{t_done, 1'b1, idx, p, 1'b0});
        last_owner = idx;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        tick();
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        sb.delete();
        last_owner = 1'b1;
        reset = 1'b0;
        tick();
    endtask

    // k < 0: no abort; otherwise abort asserted while contador = start + k.
    task automatic issue(input bit r0, input bit r1,
                         input logic [W-1:0] s0, input logic [W-1:0] p0,
                         input logic [W-1:0] s1, input logic [W-1:0] p1,
                         input int k);
        int t0, td;
        bit w;
        logic [W-1:0] s, p;
        start0 = s0; stop0 = p0; start1 = s1; stop1 = p1;
        req0 = r0; req1 = r1;
        t0 = cyc;
        if (r0 && r1) begin
            w = ~last_owner;
            push_run(w,  w ? s1 : s0,  w ? p1 : p0,  t0 + 1, td);
            push_run(~w, ~w ? s1 : s0, ~w ? p1 : p0, td + 2, td);
        end else begin
            w = r1;
            s = w ? s1 : s0;
            p = w ? p1 : p0;
            if (k >= 0) begin
                sb.push_back('{t0 + 1, 1'b0, w, s, 1'b0});
                sb.push_back('{t0 + 2 + k, 1'b1, w, s + W'(k), 1'b1});
                last_owner = w;
            end else begin
                push_run(w, s, p, t0 + 1, td);
            end
        end
        if (k >= 0) begin
            repeat (k + 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        int t0, td, mode, k;
        logic [W-1:0] s, p, d;
        reset = 1'b1; abort = 1'b0; req1 = 1'b0;
        req0 = 1'b1; start0 = 4'd5; stop0 = 4'd7; start1 = '0; stop1 = '0;
        last_owner = 1'b1;

        // Reset held with a pending request: nothing may happen.
        repeat (3) begin
            tick();
            check("reset_contador", contador, 0);
            check("reset_busy",     busy,     0);
            check("reset_ack0",     ack0,     0);
            check("reset_owner",    owner,    0);
        end
        reset = 1'b0;
        t0 = cyc;
        push_run(1'b0, 4'd5, 4'd7, t0 + 1, td);
        wait_drain();

        issue(1, 0, 4'd3,  4'd7,  4'd0,  4'd0, -1);
        issue(0, 1, 4'd0,  4'd0,  4'd14, 4'd2, -1);
        do_reset();
        issue(1, 1, 4'd0,  4'd1,  4'd5,  4'd6, -1);
        issue(1, 0, 4'd0,  4'd15, 4'd0,  4'd0, 4);
        issue(1, 0, 4'd9,  4'd9,  4'd0,  4'd0, -1);

        // Reset in the middle of a run discards it without a done pulse.
        start0 = 4'd0; stop0 = 4'd15; req0 = 1'b1;
        t0 = cyc;
        sb.push_back('{t0 + 1, 1'b0, 1'b0, 4'd0, 1'b0});
        repeat (7) tick();
        check("midrun_contador", contador, 6);
        reset = 1'b1;
        tick();
        check("midrun_reset_contador", contador, 0);
        check("midrun_reset_busy",     busy,     0);
        check("midrun_reset_owner",    owner,    0);
        reset = 1'b0;
        last_owner = 1'b1;
        repeat (20) tick();
        check("midrun_no_done_pending", sb.size(), 0);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            s = W'($urandom); p = W'($urandom);
            d = p - s;
            case (mode)
                0: issue(1, 0, s, p, W'($urandom), W'($urandom), -1);
                1: issue(0, 1, W'($urandom), W'($urandom), s, p, -1);
                2: issue(1, 1, s, p, W'($urandom), W'($urandom), -1);
                default: begin
                    k = (d == 0) ? -1 : $urandom_range(0, int'(d) - 1);
                    if ($urandom_range(0, 1) == 0) issue(1, 0, s, p, 4'd0, 4'd0, k);
                    else                           issue(0, 1, 4'd0, 4'd0, s, p, k);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
